cplx_delay_line: RTL

CPLX_DELAY_LINE -- requirements
Module: cplx_delay_line

---
 rtl/cplx_delay_line.sv | 63 ++++++
 1 files changed

// File: rtl/cplx_delay_line.sv
// Fixed-depth enabled delay line for packed complex sample words, tracking valid occupancy.
// Optional synchronous flush port clr is compiled in with `define CPLX_DELAY_LINE_CLR_EN.
module cplx_delay_line #(
  parameter int NB    = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
`ifdef CPLX_DELAY_LINE_CLR_EN
  input  logic                             clr,
`endif
  input  logic                             en,
  input  logic [2*NB*LANES-1:0]            din,
  input  logic                             din_valid,
  output logic [2*NB*LANES-1:0]            dout,
  output logic                             dout_valid,
  output logic [$clog2(DEPTH+1)-1:0]       fill_cnt,
  output logic                             primed
);

  localparam int W  = 2 * NB * LANES;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0] stg_dat [DEPTH];
  logic [DEPTH-1:0] stg_vld;
  logic flush;

`ifdef CPLX_DELAY_LINE_CLR_EN
  assign flush = clr;
`else
  assign flush = 1'b0;
`endif

  // Data moves every enabled cycle whether or not it is valid; only flags gate meaning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stg_dat[i] <= '0;
      stg_vld  <= '0;
      fill_cnt <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stg_dat[i] <= '0;
      stg_vld  <= '0;
      fill_cnt <= '0;
    end else if (en) begin
      stg_dat[0] <= din;
      stg_vld[0] <= din_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stg_dat[i] <= stg_dat[i-1];
        stg_vld[i] <= stg_vld[i-1];
      end
      if (din_valid && !stg_vld[DEPTH-1])
        fill_cnt <= fill_cnt + CW'(1);
      else if (!din_valid && stg_vld[DEPTH-1])
        fill_cnt <= fill_cnt - CW'(1);
    end
  end

  assign dout       = stg_dat[DEPTH-1];
  assign dout_valid = stg_vld[DEPTH-1];
  assign primed     = (fill_cnt == CW'(DEPTH));

endmodule
